// File: rtl/pending_priority_encoder_pkg.sv
// Shared helpers for the pending priority encoder: index/count widths, popcount, round-robin mask.
// Pure functions only; no state, no handshake.
// Used at elaboration time (widths) and in combinational logic (popcount, mask).
package penc_pkg;

  localparam int MAX_N = 64;

  // Width needed to hold values 0..n-1, never less than 1.
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  // Width needed to hold values 0..n.
  function automatic int cnt_width(input int n);
    return idx_width(n + 1);
  endfunction

  function automatic logic [6:0] popcount(input logic [MAX_N-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < MAX_N; i++) c = c + 7'(v[i]);
    return c;
  endfunction

  // Bits strictly below the last granted index. A pointer of 0 yields an empty
  // mask, so the search falls back to the full vector and wraps to N-1.
  function automatic logic [MAX_N-1:0] rr_below_mask(input logic [5:0] ptr);
    return (64'd1 << ptr) - 64'd1;
  endfunction

endpackage

// File: rtl/pending_priority_encoder_if.sv
// Request/grant bundle between request sources, the pending encoder and its consumer.
// master: the encoder side; slave: sources plus the consumer.
// Backpressure: the consumer holds ready low to keep q/valid stable.
interface pending_priority_encoder_if
  import penc_pkg::*;
#(
  parameter int N  = 10,
  parameter int W  = idx_width(N),
  parameter int CW = cnt_width(N)
);
  logic [N-1:0]  d;
  logic          ready;
  logic [W-1:0]  q;
  logic          valid;
  logic [N-1:0]  pending;
  logic [CW-1:0] count;
  logic          dup;

  modport master (
    input  d,
    input  ready,
    output q,
    output valid,
    output pending,
    output count,
    output dup
  );

  modport slave (
    output d,
    output ready,
    input  q,
    input  valid,
    input  pending,
    input  count,
    input  dup
  );

endinterface

// File: rtl/pending_priority_encoder_comb.sv
// Combinational N-to-W highest-set-bit encoder with an any-bit-set flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none; idx is 0 when no bit is set.
module priority_encoder_comb #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  // Ascending scan so the highest set bit is the last assignment to stick.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pending_priority_encoder.sv
// Sticky pending-request register drained one index per valid/ready accept; optional PENC_ROUND_ROBIN_EN.
// Latency: d[i] in cycle t shows as pending/valid in cycle t+1; q/valid/count are combinational from pending.
// Backpressure: ready low holds the pending set; new requests keep accumulating and repeats raise dup.
module pending_priority_encoder
  import penc_pkg::*;
#(
  parameter int N = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  pending_priority_encoder_if.master bus
);

  localparam int W  = idx_width(N);
  localparam int CW = cnt_width(N);

  logic [N-1:0] p_q;
  logic         dup_q;
  logic [W-1:0] win_idx;
  logic         win_any;
  logic         accept;
  logic [N-1:0] grant;

`ifdef PENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q;
  logic [N-1:0] p_below;
  logic [W-1:0] lo_idx;
  logic         lo_any;
  logic [W-1:0] all_idx;
  logic         all_any;

  assign p_below = p_q & N'(rr_below_mask(6'(ptr_q)));

  priority_encoder_comb #(.N(N), .W(W)) u_enc_lo (
    .req (p_below),
    .idx (lo_idx),
    .any (lo_any)
  );

  priority_encoder_comb #(.N(N), .W(W)) u_enc_all (
    .req (p_q),
    .idx (all_idx),
    .any (all_any)
  );

  // Nothing below the pointer means the search wraps to the top of the vector.
  assign win_idx = lo_any ? lo_idx : all_idx;
  assign win_any = all_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= win_idx;
    end
  end
`else
  priority_encoder_comb #(.N(N), .W(W)) u_enc (
    .req (p_q),
    .idx (win_idx),
    .any (win_any)
  );
`endif

  assign accept = win_any && bus.ready;
  assign grant  = accept ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;

  // A request landing on its own grant cycle re-sets the bit: d wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      dup_q <= 1'b0;
    end else begin
      p_q   <= (p_q & ~grant) | bus.d;
      dup_q <= |(bus.d & p_q & ~grant);
    end
  end

  assign bus.q       = win_idx;
  assign bus.valid   = win_any;
  assign bus.pending = p_q;
  assign bus.count   = CW'(popcount(64'(p_q)));
  assign bus.dup     = dup_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Directed-vector bench for pending_priority_encoder (N=10), fixed or PENC_ROUND_ROBIN_EN build.
module tb_pending_priority_encoder;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  pending_priority_encoder_if #(.N(10)) bus ();

  pending_priority_encoder #(.N(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [63:0] starve_exp [3];

  initial begin
    vectors     = 0;
    miscompares = 0;
`ifdef PENC_ROUND_ROBIN_EN
    starve_exp[0] = 64'd9; starve_exp[1] = 64'd5; starve_exp[2] = 64'd9;
`else
    starve_exp[0] = 64'd9; starve_exp[1] = 64'd9; starve_exp[2] = 64'd9;
`endif

    // Reset with all requests asserted: reset must win.
    rst       = 1'b1;
    bus.d     = 10'h3FF;
    bus.ready = 1'b0;
    tick();
    tick();
    check("rst_valid",   64'(bus.valid),   64'd0);
    check("rst_q",       64'(bus.q),       64'd0);
    check("rst_pending", 64'(bus.pending), 64'd0);
    check("rst_count",   64'(bus.count),   64'd0);
    check("rst_dup",     64'(bus.dup),     64'd0);
    rst   = 1'b0;
    bus.d = '0;
    tick();

    // Capture and hold with ready low.
    bus.d = 10'b0000000101;
    tick();
    bus.d = '0;
    check("cap_valid", 64'(bus.valid), 64'd1);
    check("cap_q",     64'(bus.q),     64'd2);
    check("cap_count", 64'(bus.count), 64'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_q",     64'(bus.q),     64'd2);
      check("hold_count", 64'(bus.count), 64'd2);
    end
    bus.ready = 1'b1;
    tick();
    check("cap_drain_q",     64'(bus.q),     64'd0);
    check("cap_drain_valid", 64'(bus.valid), 64'd1);
    tick();
    check("cap_empty", 64'(bus.valid), 64'd0);

    // Drain order with ready held high.
    bus.d = 10'b1010101010;
    tick();
    bus.d = '0;
    check("drain_q9", 64'(bus.q), 64'd9);
    tick();
    check("drain_q7", 64'(bus.q), 64'd7);
    tick();
    check("drain_q5", 64'(bus.q), 64'd5);
    tick();
    check("drain_q3", 64'(bus.q), 64'd3);
    tick();
    check("drain_q1", 64'(bus.q), 64'd1);
    check("drain_v1", 64'(bus.valid), 64'd1);
    tick();
    check("drain_empty", 64'(bus.valid), 64'd0);

    // Duplicate request on an already-pending, ungranted bit.
    bus.ready = 1'b0;
    bus.d     = 10'b0000001000;
    tick();
    check("dup_first", 64'(bus.dup), 64'd0);
    tick();
    bus.d = '0;
    check("dup_pulse", 64'(bus.dup),   64'd1);
    check("dup_count", 64'(bus.count), 64'd1);
    tick();
    check("dup_clear", 64'(bus.dup), 64'd0);

    // Request on its own accept cycle keeps the bit pending without dup.
    bus.ready = 1'b1;
    bus.d     = 10'b0000001000;
    tick();
    bus.d     = '0;
    bus.ready = 1'b0;
    check("coll_pending", 64'(bus.pending), 64'h008);
    check("coll_dup",     64'(bus.dup),     64'd0);
    check("coll_q",       64'(bus.q),       64'd3);
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    check("coll_empty", 64'(bus.valid), 64'd0);

    // Starvation: bit 9 re-pulsed on every accept alongside bit 5.
    bus.d = 10'b1000100000;
    tick();
    bus.d = '0;
    check("starve_pending", 64'(bus.pending), 64'h220);
    bus.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("starve_q", 64'(bus.q), starve_exp[i]);
      bus.d = 10'b1000000000;
      tick();
    end
    bus.d     = '0;
    bus.ready = 1'b0;

    // Reset mid-drain discards everything.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    bus.d = 10'h0F0;
    tick();
    bus.d = '0;
    check("mid_pending0", 64'(bus.pending), 64'h0F0);
    check("mid_q7",       64'(bus.q),       64'd7);
    bus.ready = 1'b1;
    tick();
    check("mid_pending1", 64'(bus.pending), 64'h070);
    check("mid_q6",       64'(bus.q),       64'd6);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    bus.ready = 1'b0;
    check("mid_rst_pending", 64'(bus.pending), 64'd0);
    check("mid_rst_valid",   64'(bus.valid),   64'd0);
    check("mid_rst_count",   64'(bus.count),   64'd0);
    bus.d = 10'h001;
    tick();
    bus.d = '0;
    check("post_q",     64'(bus.q),     64'd0);
    check("post_valid", 64'(bus.valid), 64'd1);
    check("post_count", 64'(bus.count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
